// File: rtl/vid_line_reader_pkg.sv
// Shared definitions for the video line reader: FSM states, FIFO word
// field layout and the raster constants shared with the timing generator.
package vid_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    RUN        = 2'd1,
    FLUSH      = 2'd2
  } state_e;

  // FIFO word layout: {line_tag[10:0], rgb[23:0]}
  localparam int TAG_LSB = 24;
  localparam int TAG_W   = 11;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_START_DEF  = 25;
  localparam int V_ACTIVE_DEF = 720;

endpackage

// File: rtl/vid_line_reader_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vid_line_reader.sv
// Aligns tagged FWFT line-FIFO words to the raster, drops stale/garbage words,
// fills on underrun and drives registered, delay-matched video to the encoder.
module vid_line_reader
  import vid_pkg::*;
#(
  parameter int                 H_ACTIVE = H_ACTIVE_DEF,
  parameter int                 V_START  = V_START_DEF,
  parameter int                 V_ACTIVE = V_ACTIVE_DEF,
  parameter int                 RGB_W    = 24,
  parameter logic [RGB_W-1:0]   FILL_RGB = '0
) (
  input  logic                      clk74m,
  input  logic                      rst_n,
  input  logic [10:0]               hcount,
  input  logic [10:0]               vcount,
  input  logic                      hblnk,
  input  logic                      vblnk,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic                      resync,
  input  logic                      fifo_empty,
  input  logic [TAG_LSB+TAG_W-1:0]  fifo_dout,
  output logic                      fifo_rd_en,
  output logic                      vid_de,
  output logic                      vid_hsync,
  output logic                      vid_vsync,
  output logic [RGB_W-1:0]          vid_rgb,
  output logic                      underrun,
  output logic [15:0]               underrun_cnt,
  output logic [15:0]               drop_cnt
);

  localparam logic [10:0] H_ACTIVE_L = 11'(H_ACTIVE);
  localparam logic [10:0] V_START_L  = 11'(V_START);
  localparam logic [10:0] V_END_L    = 11'(V_START + V_ACTIVE);
  localparam logic [10:0] V_ACTIVE_L = 11'(V_ACTIVE);

  state_e state_q, state_d;

  logic             active;
  logic             vact;
  logic [10:0]      line_idx;
  logic [10:0]      tag;
  logic [RGB_W-1:0] fifo_rgb;
  logic             garbage;
  logic             pop_pix;
  logic             pop_drop;

  logic             de_q, de_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             ur_q, ur_d;

  // The hcount bound only matters if a generator's hblnk is narrower than the line.
  assign active   = !hblnk && !vblnk && (hcount < H_ACTIVE_L);
  assign vact     = (vcount >= V_START_L) && (vcount < V_END_L);
  assign line_idx = vcount - V_START_L;
  assign tag      = fifo_dout[TAG_LSB +: TAG_W];
  assign fifo_rgb = fifo_dout[RGB_W-1:0];
  assign garbage  = (tag >= V_ACTIVE_L);

  always_comb begin
    state_d  = state_q;
    pop_pix  = 1'b0;
    pop_drop = 1'b0;
    case (state_q)
      WAIT_FRAME: begin
        pop_drop = !fifo_empty && garbage;
        if ((vcount == 11'd0) && (hcount == 11'd0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        pop_pix  = active && !fifo_empty && (tag == line_idx);
        // Outside vact only garbage goes; the next frame's line 0 must survive the bottom blank.
        pop_drop = !fifo_empty && !pop_pix &&
                   (garbage || (vact && (tag < line_idx)));
      end
      FLUSH: begin
        pop_drop = !fifo_empty;
        if (fifo_empty) begin
          state_d = WAIT_FRAME;
        end
      end
      default: begin
        state_d = WAIT_FRAME;
      end
    endcase
    if (resync) begin
      state_d = FLUSH;
    end
  end

  assign fifo_rd_en = pop_pix || pop_drop;

  always_comb begin
    de_d  = active;
    hs_d  = hsync;
    vs_d  = vsync;
    rgb_d = pop_pix ? fifo_rgb : FILL_RGB;
    ur_d  = (state_q == RUN) && active && !pop_pix;
  end

  always_ff @(posedge clk74m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_FRAME;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      rgb_q   <= FILL_RGB;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
      ur_q    <= ur_d;
    end
  end

  assign vid_de    = de_q;
  assign vid_hsync = hs_q;
  assign vid_vsync = vs_q;
  assign vid_rgb   = rgb_q;
  assign underrun  = ur_q;

  sat_cnt16 u_underrun_cnt (
    .clk   (clk74m),
    .rst_n (rst_n),
    .en    (ur_d),
    .cnt   (underrun_cnt)
  );

  sat_cnt16 u_drop_cnt (
    .clk   (clk74m),
    .rst_n (rst_n),
    .en    (pop_drop),
    .cnt   (drop_cnt)
  );

endmodule
